// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined adder: chunk sizing, configuration legality
// and the signed-overflow rule.
package adder_pkg;

    function automatic int chunk_width(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

    // Legal configurations: 1..WIDTH stages, each resolving the same number of bits.
    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    function automatic logic ovf_flag(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/pipelined_adder_chunk.sv
// CHUNK-bit ripple adder built from per-bit full-adder equations.
// Latency: purely combinational, no registers.
// Backpressure: none; the enclosing pipeline decides when the result is captured.
module pipelined_adder_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    assign cout = c[CHUNK];

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder with the carry chain cut into STAGES register stages; optional subtract via PIPELINED_ADDER_SUB_EN.
// Latency: STAGES cycles from accept to out_valid, plus one per stall cycle.
// Backpressure: global stall, the whole pipe holds whenever out_valid && !out_ready.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
    end

    logic             advance;
    logic             rdy_q;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Stage inputs: index 0 comes from the ports, index k from register k-1.
    logic [WIDTH-1:0]  a_in  [STAGES];
    logic [WIDTH-1:0]  b_in  [STAGES];
    logic [WIDTH-1:0]  s_in  [STAGES];
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] v_in;

    logic [WIDTH-1:0]  chunk_sum;
    logic [STAGES-1:0] chunk_cout;
    logic [WIDTH-1:0]  s_nxt [STAGES];

    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  s_q   [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] vld_q;

    // Subtraction is folded into the operands at entry, so only the effective
    // B and carry-in travel with the beat.
`ifdef PIPELINED_ADDER_SUB_EN
    assign b_eff   = in_sub ? ~in_b : in_b;
    assign cin_eff = in_sub ? 1'b1  : in_cin;
`else
    assign b_eff   = in_b;
    assign cin_eff = in_cin;
`endif

    // Holds in_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && rdy_q;

    always_comb begin
        a_in[0] = in_a;
        b_in[0] = b_eff;
        s_in[0] = '0;
        c_in    = '0;
        v_in    = '0;
        c_in[0] = cin_eff;
        v_in[0] = in_valid && rdy_q;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
            c_in[k] = c_q[k-1];
            v_in[k] = vld_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipelined_adder_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a    (a_in[k][k*CHUNK +: CHUNK]),
            .b    (b_in[k][k*CHUNK +: CHUNK]),
            .cin  (c_in[k]),
            .sum  (chunk_sum[k*CHUNK +: CHUNK]),
            .cout (chunk_cout[k])
        );
    end

    // Each stage drops its freshly resolved chunk into the travelling sum.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_nxt[k]                     = s_in[k];
            s_nxt[k][k*CHUNK +: CHUNK]   = chunk_sum[k*CHUNK +: CHUNK];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            c_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (advance) begin
            vld_q <= v_in;
            c_q   <= chunk_cout;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= s_nxt[k];
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out_sum   = s_q[STAGES-1];
    assign out_cout  = c_q[STAGES-1];
    assign out_ovf   = ovf_flag(a_q[STAGES-1][WIDTH-1], b_q[STAGES-1][WIDTH-1],
                                s_q[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed corner sums, stalled and
// random streams against a queue-based reference model, and mid-flight reset.
module tb_pipelined_adder;

    localparam int W = 32;
    localparam int S = 4;
`ifdef PIPELINED_ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, in_cin, in_sub;
    logic         out_valid, out_ready, out_cout, out_ovf;
    logic [W-1:0] in_a, in_b, out_sum;

    logic         s_vld, s_cin;
    logic [3:0]   s1_a, s1_b, s1_sum;
    logic         s1_ir, s1_ov, s1_cout, s1_ovf;
    logic [7:0]   s8_a, s8_b, s8_sum;
    logic         s8_ir, s8_ov, s8_cout, s8_ovf;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk (clk), .rst_n (rst_n),
        .in_valid (in_valid), .in_ready (in_ready),
        .in_a (in_a), .in_b (in_b), .in_cin (in_cin),
`ifdef PIPELINED_ADDER_SUB_EN
        .in_sub (in_sub),
`endif
        .out_valid (out_valid), .out_ready (out_ready),
        .out_sum (out_sum), .out_cout (out_cout), .out_ovf (out_ovf)
    );

    pipelined_adder #(.WIDTH(4), .STAGES(1)) dut_s1 (
        .clk (clk), .rst_n (rst_n),
        .in_valid (s_vld), .in_ready (s1_ir),
        .in_a (s1_a), .in_b (s1_b), .in_cin (s_cin),
`ifdef PIPELINED_ADDER_SUB_EN
        .in_sub (1'b0),
`endif
        .out_valid (s1_ov), .out_ready (1'b1),
        .out_sum (s1_sum), .out_cout (s1_cout), .out_ovf (s1_ovf)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(8)) dut_s8 (
        .clk (clk), .rst_n (rst_n),
        .in_valid (s_vld), .in_ready (s8_ir),
        .in_a (s8_a), .in_b (s8_b), .in_cin (s_cin),
`ifdef PIPELINED_ADDER_SUB_EN
        .in_sub (1'b0),
`endif
        .out_valid (s8_ov), .out_ready (1'b1),
        .out_sum (s8_sum), .out_cout (s8_cout), .out_ovf (s8_ovf)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t         q[$];
    int           checks = 0;
    int           errors = 0;
    int           n_out = 0;
    int           stall_cnt = 0;
    bit           sb_en = 1'b0;
    bit           acc = 1'b0;
    bit           held = 1'b0;
    logic [W-1:0] h_sum;
    logic [1:0]   h_flags;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Arithmetic reference: plain integer add/subtract, overflow by range test.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t        e;
        logic [W:0]  u;
        longint      r;
        longint      lim;
        lim = longint'(1) << (W - 1);
        if (sub) begin
            e.sum  = a - b;
            e.cout = (a >= b);
            r      = longint'($signed(a)) - longint'($signed(b));
        end else begin
            u      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            e.sum  = u[W-1:0];
            e.cout = u[W];
            r      = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        end
        e.ovf = (r > lim - 1) || (r < -lim);
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom % 5)
            0:       return '1;
            1:       return 32'h8000_0000;
            2:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // One clock: sample/score at the falling edge, then step past the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (held) begin
            check("hold_valid", out_valid, 1);
            check("hold_sum", out_sum, h_sum);
            check("hold_flags", {out_cout, out_ovf}, h_flags);
        end
        held = out_valid && !out_ready;
        if (held) begin
            h_sum   = out_sum;
            h_flags = {out_cout, out_ovf};
            stall_cnt++;
            check("stall_in_ready", in_ready, 0);
        end
        if (sb_en && out_valid && out_ready) begin
            n_out++;
            check("out_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("sum", out_sum, e.sum);
                check("cout", out_cout, e.cout);
                check("ovf", out_ovf, e.ovf);
            end
        end
        acc = in_valid && in_ready;
        if (sb_en && acc) q.push_back(model(in_a, in_b, in_cin, in_sub));
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub, input logic [W-1:0] es,
                            input logic ec, input logic eo);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub;
        check({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, S);
        check({tag, "_sum"}, out_sum, es);
        check({tag, "_cout"}, out_cout, ec);
        check({tag, "_ovf"}, out_ovf, eo);
    endtask

    task automatic run_stream(input string tag, input int nb, input bit rnd_flow);
        int idx = 0;
        int n = 0;
        int stalls0;
        bit have = 1'b0;
        stalls0 = stall_cnt;
        while ((idx < nb || q.size() != 0) && n < 2000) begin
            if (!have && idx < nb) begin
                in_a   = pick();
                in_b   = pick();
                in_cin = 1'($urandom % 2);
                in_sub = SUB_EN ? 1'($urandom % 2) : 1'b0;
                have   = 1'b1;
            end
            in_valid  = have && (rnd_flow ? ($urandom % 4 != 0) : 1'b1);
            out_ready = rnd_flow ? ($urandom % 3 != 0) : !(n >= 7 && n < 10);
            tick();
            if (acc) begin
                have = 1'b0;
                idx++;
            end
            n++;
        end
        check({tag, "_beats"}, idx, nb);
        check({tag, "_drain"}, q.size(), 0);
        if (!rnd_flow) check({tag, "_stall_cycles"}, stall_cnt - stalls0, 3);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int          l1, l8, n_out0, d;
        logic [5:0]  r1;
        logic [9:0]  r8;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        out_ready = 1'b1; s_vld = 1'b0; s_cin = 1'b0;
        s1_a = '0; s1_b = '0; s8_a = '0; s8_b = '0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_cout", out_cout, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("in_ready_before_clk", in_ready, 0);
        tick();
        check("in_ready_after_clk", in_ready, 1);

        directed("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        directed("posovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        directed("negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
`ifdef PIPELINED_ADDER_SUB_EN
        directed("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        directed("sub_ovf", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
`endif
        in_sub = 1'b0;
        repeat (6) tick();

        // Degenerate shapes: single stage and one bit per stage.
        s_vld = 1'b1; s_cin = 1'b1;
        s1_a = 4'd9; s1_b = 4'd8; s8_a = 8'hAA; s8_b = 8'h55;
        check("s1_in_ready", s1_ir, 1);
        check("s8_in_ready", s8_ir, 1);
        tick();
        s_vld = 1'b0;
        l1 = 0; l8 = 0; r1 = '0; r8 = '0;
        for (int i = 1; i <= 12; i++) begin
            if (s1_ov && l1 == 0) begin l1 = i; r1 = {s1_cout, s1_ovf, s1_sum}; end
            if (s8_ov && l8 == 0) begin l8 = i; r8 = {s8_cout, s8_ovf, s8_sum}; end
            if (i < 12) tick();
        end
        check("s1_latency", l1, 1);
        check("s1_result", r1, {1'b1, 1'b1, 4'h2});
        check("s8_latency", l8, 8);
        check("s8_result", r8, {1'b1, 1'b0, 8'h00});

        sb_en = 1'b1;
        run_stream("stall", 16, 1'b0);
        run_stream("random", 40, 1'b1);

        // Reset with three beats in flight; only later beats may emerge.
        in_sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_cin = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        check("inflight_beats", q.size(), 3);
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_in_ready", in_ready, 0);
        q.delete();
        held = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 1);
        n_out0 = n_out;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = pick(); in_b = pick(); in_cin = 1'($urandom % 2);
            tick();
        end
        in_valid = 1'b0;
        d = 0;
        while (q.size() != 0 && d < 50) begin
            tick();
            d++;
        end
        repeat (6) tick();
        check("post_rst_drain", q.size(), 0);
        check("post_rst_out_count", n_out - n_out0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the team's 4-bit ripple-carry adder.
- Adds two WIDTH-bit operands plus carry-in. The carry chain is split into STAGES equal chunks, one chunk per register stage.
- Data moves through a valid/ready stream with backpressure.
- Used as the shared datapath adder wherever WIDTH is too large for a single-cycle ripple chain.

Parameters:
- WIDTH, 32, operand/sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH); CHUNK = WIDTH/STAGES bits are resolved per stage.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  WIDTH  sum bits.
- out_cout  out  1  carry out of the MSB.
- out_ovf  out  1  two's-complement signed overflow.

Behaviour:
- Reset (async assert, sync-released by the environment): all stage valid bits = 0, all data registers = 0. Outputs: out_valid=0, out_sum=0, out_cout=0, out_ovf=0. in_ready becomes 1 on the first clock after reset deasserts. Beats in flight at reset are discarded.
- Global stall: advance = !out_valid || out_ready; in_ready = advance (combinational).
- On advance, every stage register loads from the previous stage. Stage 0 loads {in_valid, operands, in_cin}. Bubbles are not collapsed. When advance = 0, all stages hold.
- Accept: in_valid && in_ready.
- Stage k (0..STAGES-1) computes chunk k = a[k*CHUNK +: CHUNK] + b[same] + carry_k, where carry_0 = in_cin and carry_k is the registered carry from stage k-1.
  - Result chunks below k travel forward in registers.
  - Operand chunks above k travel forward unmodified (skew registers).
- Latency: a beat accepted at edge N has out_valid=1 after edge N+STAGES, provided no stall occurs. Each stall cycle adds one cycle.
- Throughput: one beat per cycle while out_ready=1.
- out_cout = carry out of bit WIDTH-1.
- out_ovf = (a[MSB]==b'[MSB]) && (sum[MSB]!=a[MSB]), where b' is the effective B operand.
- Results leave in the same order beats were accepted; no beat is dropped or duplicated.
- Output stability: while out_valid && !out_ready, out_sum, out_cout and out_ovf hold stable.
- Simultaneous accept and output handshake in the same cycle is legal and required at full rate.
- STAGES=1: single registered adder, latency 1.
- STAGES=WIDTH: CHUNK=1, one full adder per stage.

Optional Feature:
- Macro: PIPELINED_ADDER_SUB_EN.
- When defined:
  - Adds input port in_sub (1 bit), registered with the beat.
  - in_sub=1: effective B = ~in_b and carry-in = 1; in_cin is ignored. out_cout = NOT borrow.
  - in_sub=0: behaviour identical to the undefined case.
- When undefined: no in_sub port; effective B = in_b.

Decomposition:
- Shared package adder_pkg holds:
  - function/localparam for CHUNK derivation;
  - the WIDTH % STAGES == 0 elaboration check;
  - overflow-flag helper function.
- Sub-module pipelined_adder_chunk: combinational CHUNK-bit ripple adder built from per-bit full-adder equations (sum = a^b^c; carry = majority). One instance per stage, generated by a loop.

Test Plan:
- WIDTH=32, STAGES=4: a=0xFFFFFFFF, b=0x00000001, cin=0 -> out_sum=0x00000000, cout=1, ovf=0; out_valid exactly 4 cycles after accept.
- a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1. Then a=0x80000000, b=0x80000000 -> sum=0, cout=1, ovf=1.
- Streaming and stall:
  - 16 back-to-back random beats; out_ready held low for 3 cycles mid-stream.
  - in_ready must be 0 during the stall and outputs must hold.
  - All 16 results must match the reference model, in order, with none lost.
- Reset mid-operation: assert rst_n=0 with 3 beats in flight -> out_valid=0 immediately (async). After release, only post-reset beats emerge.
- WIDTH=4, STAGES=1: a=9, b=8, cin=1 -> sum=2, cout=1, latency 1. WIDTH=8, STAGES=8: a=0xAA, b=0x55, cin=1 -> sum=0x00, cout=1, latency 8.
- With PIPELINED_ADDER_SUB_EN, WIDTH=32: in_sub=1, a=5, b=7 -> sum=0xFFFFFFFE, cout=0, ovf=0. in_sub=1, a=0x80000000, b=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
